mips_mc_core: RTL and testbench

- Parametrised multi-cycle execution core for the 32-bit MIPS-subset ISA: fetch, decode, execute, memory and writeback.
- Contains the register file and the data RAM, and fetches instructions over a req/valid handshake from an external instruction memory.
- Generalises the earlier single-stage CPU harness with configurable depths, a reset PC, a fixed PC-relative branch, and trap/halt handling.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/mips_alu.sv | 25 ++
 rtl/mips_mc_core.sv | 189 ++++++++++++++++++
 tb/tb_mips_mc_core.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset core: opcodes, function
// codes, sequencer states and ALU operations.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SLL = 6'h00;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL
  } alu_op_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU for the multi-cycle core; slt compares as signed.
module mips_alu
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  input  alu_op_t     alu_op,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {31'b0, ($signed(a) < $signed(b))};
      ALU_SLL: result = b << shamt;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mips_mc_core.sv
// Multi-cycle MIPS-subset core: FSM sequencer, register file, data RAM and a
// req/valid instruction fetch port.
module mips_mc_core
  import mips_pkg::*;
#(
  parameter int unsigned     NREG       = 32,
  parameter int unsigned     DMEM_DEPTH = 4096,
  parameter int unsigned     PC_W       = 16,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  output logic [PC_W-1:0] pc,
  output logic            retire,
  output logic            halted,
  output logic            trap,
  input  logic [4:0]      dbg_sel,
  output logic [31:0]     dbg_data
);

  localparam int unsigned RW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int unsigned AW = $clog2(DMEM_DEPTH);

  state_t          state, state_nx;
  logic [31:0]     ir, a_q, b_q, alu_q, mdr;
  logic [31:0]     regs [NREG];
  logic [31:0]     dmem [DMEM_DEPTH];
  logic [PC_W-1:0] pc_q, pc_nx, pc_inc, br_target;
  logic            trap_q;

  logic [5:0]      opcode, funct;
  logic [RW-1:0]   rs, rt, rd, waddr;
  logic [4:0]      shamt;
  logic [31:0]     imm_ext, alu_b, alu_result, wdata;
  logic [AW-1:0]   maddr;
  logic            legal, use_imm, reg_we;
  alu_op_t         alu_op;

  assign opcode  = ir[31:26];
  assign rs      = ir[21 +: RW];
  assign rt      = ir[16 +: RW];
  assign rd      = ir[11 +: RW];
  assign shamt   = ir[10:6];
  assign funct   = ir[5:0];
  assign imm_ext = sext16(ir[15:0]);

  always_comb begin
    legal   = 1'b1;
    use_imm = 1'b0;
    alu_op  = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLL:  alu_op = ALU_SLL;
          default: legal  = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: use_imm = 1'b1;
      OP_BEQ, OP_J, OP_HALT: begin end
      default: legal = 1'b0;
    endcase
  end

  assign alu_b = use_imm ? imm_ext : b_q;

  mips_alu u_alu (
    .a      (a_q),
    .b      (alu_b),
    .shamt  (shamt),
    .alu_op (alu_op),
    .result (alu_result)
  );

  // Branch target wraps naturally at PC_W bits.
  assign pc_inc    = pc_q + PC_W'(1);
  assign br_target = pc_inc + imm_ext[PC_W-1:0];

  always_comb begin
    state_nx = state;
    retire   = 1'b0;
    case (state)
      S_IDLE:   if (run) state_nx = S_FETCH;
      S_FETCH:  if (imem_valid) state_nx = S_DECODE;
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        if (!legal) begin
          state_nx = S_HALT;
        end else begin
          case (opcode)
            OP_LW, OP_SW: state_nx = S_MEM;
            OP_BEQ, OP_J: begin
              state_nx = S_FETCH;
              retire   = 1'b1;
            end
            OP_HALT: begin
              state_nx = S_HALT;
              retire   = 1'b1;
            end
            default: state_nx = S_WB;
          endcase
        end
      end
      S_MEM: begin
        if (opcode == OP_SW) begin
          state_nx = S_FETCH;
          retire   = 1'b1;
        end else begin
          state_nx = S_WB;
        end
      end
      S_WB: begin
        state_nx = S_FETCH;
        retire   = 1'b1;
      end
      S_HALT:  if (run) state_nx = S_FETCH;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    pc_nx = pc_q;
    if (retire) begin
      case (opcode)
        OP_BEQ:  pc_nx = (a_q == b_q) ? br_target : pc_inc;
        OP_J:    pc_nx = ir[PC_W-1:0];
        OP_HALT: pc_nx = pc_q;
        default: pc_nx = pc_inc;
      endcase
    end
  end

  assign reg_we = (state == S_WB);
  assign waddr  = (opcode == OP_RTYPE) ? rd : rt;
  assign wdata  = (opcode == OP_LW) ? mdr : alu_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      pc_q   <= RESET_PC;
      trap_q <= 1'b0;
      ir     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      alu_q  <= '0;
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      state <= state_nx;
      pc_q  <= pc_nx;
      if (state == S_FETCH && imem_valid) ir <= imem_rdata;
      if (state == S_DECODE) begin
        a_q <= regs[rs];
        b_q <= regs[rt];
      end
      if (state == S_EXEC) alu_q <= alu_result;
      if (state == S_EXEC && !legal) trap_q <= 1'b1;
      else if (state == S_HALT && run) trap_q <= 1'b0;
      if (reg_we && waddr != '0) regs[waddr] <= wdata;
    end
  end

  // RAM is not reset; an asynchronous reset forces state out of S_MEM before
  // the next edge, so an aborted store never lands.
  assign maddr = alu_q[AW-1:0];

  always_ff @(posedge clk) begin
    if (state == S_MEM) begin
      if (opcode == OP_SW) dmem[maddr] <= b_q;
      mdr <= dmem[maddr];
    end
  end

  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign halted    = (state == S_HALT);
  assign trap      = trap_q;
  assign dbg_data  = regs[dbg_sel[RW-1:0]];

endmodule

// File: tb/tb_mips_mc_core.sv
// Bench for mips_mc_core: instruction-level reference model with per-cycle
// timing expectations, directed scenarios and randomized programs.
module tb_mips_mc_core;
  import mips_pkg::*;

  localparam int unsigned PC_W = 16;

  logic            clk = 1'b0;
  logic            rst_n, run, imem_req, imem_valid, retire, halted, trap;
  logic [PC_W-1:0] imem_addr, pc;
  logic [31:0]     imem_rdata, dbg_data;
  logic [4:0]      dbg_sel;

  always #5 clk = ~clk;

  mips_mc_core #(
    .NREG(32), .DMEM_DEPTH(4096), .PC_W(PC_W), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .pc(pc), .retire(retire), .halted(halted), .trap(trap),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- instruction memory and encoders ----------------
  logic [31:0] prog [256];
  localparam logic [31:0] HALT_INS = 32'hFC00_0000;

  function automatic logic [31:0] r_ins(input int rd, input int rs, input int rt,
                                        input int sh, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input int rt, input int rs,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = HALT_INS;
  endtask

  // ---------------- reference model ----------------
  logic [31:0]     m_reg  [32];
  logic [31:0]     m_dmem [4096];
  logic [PC_W-1:0] m_pc;
  logic [31:0]     m_ir;
  bit              m_idle, m_halted, m_trap, m_fetching;
  int              m_ret_cyc, m_trap_cyc;

  task automatic model_reset();
    m_pc = '0;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_idle = 1; m_halted = 0; m_trap = 0; m_fetching = 0;
    m_ret_cyc = -1; m_trap_cyc = -1;
  endtask

  // Cycles from the fetch-complete cycle to retire inclusive; 0 marks illegal.
  function automatic int lat_of(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    case (op)
      6'h00:   return (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00}) ? 4 : 0;
      6'h08:   return 4;
      6'h23:   return 5;
      6'h2B:   return 4;
      6'h04, 6'h02, 6'h3F: return 3;
      default: return 0;
    endcase
  endfunction

  task automatic model_exec();
    logic [31:0]     a, b, se, v, ea;
    logic [PC_W-1:0] nxt;
    int rs, rt, rd;
    rs = int'(m_ir[25:21]); rt = int'(m_ir[20:16]); rd = int'(m_ir[15:11]);
    a  = m_reg[rs];
    b  = m_reg[rt];
    se = {{16{m_ir[15]}}, m_ir[15:0]};
    ea = a + se;
    nxt = m_pc + 16'd1;
    m_fetching = 1;
    case (m_ir[31:26])
      6'h00: begin
        case (m_ir[5:0])
          6'h20:   v = a + b;
          6'h22:   v = a - b;
          6'h24:   v = a & b;
          6'h25:   v = a | b;
          6'h2A:   v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: v = b << m_ir[10:6];
        endcase
        if (rd != 0) m_reg[rd] = v;
      end
      6'h08: if (rt != 0) m_reg[rt] = ea;
      6'h23: if (rt != 0) m_reg[rt] = m_dmem[ea[11:0]];
      6'h2B: m_dmem[ea[11:0]] = b;
      6'h04: if (a == b) nxt = m_pc + 16'd1 + se[15:0];
      6'h02: nxt = m_ir[15:0];
      default: begin
        nxt = m_pc;
        m_fetching = 0;
        m_halted = 1;
      end
    endcase
    m_pc = nxt;
    m_ret_cyc = -1;
  endtask

  // ---------------- instruction memory responder ----------------
  int force_wait = -1;
  bit rand_stall = 0;

  initial begin
    bit in_fetch;
    int wait_left;
    in_fetch = 0; wait_left = 0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (imem_req) begin
        if (!in_fetch) begin
          in_fetch = 1;
          if (force_wait >= 0) wait_left = force_wait;
          else wait_left = rand_stall ? int'($urandom_range(0, 3)) : 0;
        end
        if (wait_left == 0) begin
          imem_valid = 1'b1;
          imem_rdata = prog[imem_addr[7:0]];
          in_fetch   = 0;
        end else begin
          imem_valid = 1'b0;
          imem_rdata = $urandom;
          wait_left--;
        end
      end else begin
        imem_valid = 1'b0;
        in_fetch   = 0;
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  bit dbg_hold = 0;
  int ret_count = 0;
  int fetch_start = 0;
  bit prev_req = 0;
  int lat_at [256];

  initial begin
    int l;
    dbg_sel = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_imem_req", imem_req, 0);
        chk("rst_retire", retire, 0);
        chk("rst_halted", halted, 0);
        chk("rst_trap", trap, 0);
        chk("rst_pc", pc, 0);
        model_reset();
        prev_req = 0;
      end else begin
        chk("retire", retire, (cyc == m_ret_cyc));
        chk("pc", pc, m_pc);
        chk("halted", halted, m_halted);
        chk("trap", trap, m_trap);
        chk("imem_req", imem_req, m_fetching);
        if (m_fetching) chk("imem_addr", imem_addr, m_pc);
        chk("dbg_data", dbg_data, m_reg[dbg_sel]);

        if (imem_req && !prev_req) fetch_start = cyc;
        prev_req = imem_req;
        if (retire) begin
          ret_count++;
          lat_at[pc[7:0]] = cyc - fetch_start + 1;
        end

        if ((m_idle || m_halted) && run) begin
          m_idle = 0; m_halted = 0; m_trap = 0; m_fetching = 1;
        end else if (m_fetching && imem_valid) begin
          m_ir = imem_rdata;
          m_fetching = 0;
          l = lat_of(m_ir);
          if (l == 0) m_trap_cyc = cyc + 2;
          else m_ret_cyc = cyc + l - 1;
        end else if (cyc == m_ret_cyc) begin
          model_exec();
        end else if (cyc == m_trap_cyc) begin
          m_trap = 1; m_halted = 1; m_trap_cyc = -1;
        end
        if (!dbg_hold) dbg_sel = 5'($urandom_range(0, 31));
      end
      cyc++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0; run = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic pulse_run();
    @(posedge clk); #2 run = 1'b1;
    @(posedge clk); #2 run = 1'b0;
  endtask

  task automatic wait_halt(input string name, input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    chk(name, halted, 1);
  endtask

  task automatic read_reg(input int r, output logic [31:0] v);
    dbg_hold = 1;
    dbg_sel  = 5'(r);
    #1 v = dbg_data;
    dbg_hold = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    logic [31:0] v;
    bit found;
    int k, a, b, d;
    rst_n = 1'b0; run = 1'b0;
    clear_prog();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // 1: addi/addi/add/halt
    clear_prog();
    prog[0] = i_ins(OP_ADDI, 1, 0, 16'd5);
    prog[1] = i_ins(OP_ADDI, 2, 0, 16'd7);
    prog[2] = r_ins(3, 1, 2, 0, FN_ADD);
    do_reset();
    ret_count = 0;
    pulse_run();
    wait_halt("t1_halt", 100);
    read_reg(3, v);
    chk("t1_r3", v, 32'd12);
    chk("t1_model_r3", m_reg[3], 32'd12);
    chk("t1_retires", ret_count, 4);
    chk("t1_pc", pc, 3);
    chk("t1_lat_add", lat_at[2], 4);

    // 2: store then load
    clear_prog();
    prog[0] = i_ins(OP_ADDI, 1, 0, 16'h1234);
    prog[1] = i_ins(OP_SW, 1, 0, 16'd8);
    prog[2] = i_ins(OP_LW, 4, 0, 16'd8);
    do_reset();
    pulse_run();
    wait_halt("t2_halt", 100);
    read_reg(4, v);
    chk("t2_r4", v, 32'h1234);
    chk("t2_lat_sw", lat_at[1], 4);
    chk("t2_lat_lw", lat_at[2], 5);

    // 3a: self-looping beq
    clear_prog();
    prog[0] = i_ins(OP_BEQ, 0, 0, 16'hFFFF);
    do_reset();
    pulse_run();
    repeat (6) @(posedge clk);
    #2 ret_count = 0;
    repeat (30) @(posedge clk);
    #2;
    chk("t3_loop_retires", ret_count, 10);
    chk("t3_loop_pc", pc, 0);
    chk("t3_lat_beq", lat_at[0], 3);

    // 3b: beq not taken
    clear_prog();
    prog[0] = i_ins(OP_ADDI, 1, 0, 16'd1);
    prog[1] = i_ins(OP_BEQ, 2, 1, 16'd2);
    do_reset();
    pulse_run();
    wait_halt("t3b_halt", 100);
    chk("t3b_pc", pc, 2);

    // 4: fetch stall of three cycles
    clear_prog();
    prog[0] = i_ins(OP_ADDI, 5, 0, 16'h0055);
    force_wait = 3;
    do_reset();
    pulse_run();
    wait_halt("t4_halt", 100);
    read_reg(5, v);
    chk("t4_r5", v, 32'h55);
    chk("t4_lat_addi", lat_at[0], 7);
    chk("t4_lat_halt", lat_at[1], 6);
    force_wait = -1;

    // 5: illegal opcode, then resume
    clear_prog();
    prog[0] = 32'hF800_0000;
    do_reset();
    ret_count = 0;
    pulse_run();
    wait_halt("t5_halt", 100);
    chk("t5_trap", trap, 1);
    chk("t5_retires", ret_count, 0);
    chk("t5_pc", pc, 0);
    pulse_run();
    chk("t5_trap_clear", trap, 0);
    chk("t5_refetch", imem_req, 1);
    wait_halt("t5_retrap", 100);

    // 5b: unlisted funct
    clear_prog();
    prog[0] = i_ins(OP_ADDI, 1, 0, 16'd3);
    prog[1] = r_ins(2, 1, 1, 0, 6'h21);
    do_reset();
    pulse_run();
    wait_halt("t5b_halt", 100);
    chk("t5b_trap", trap, 1);
    chk("t5b_pc", pc, 1);
    read_reg(2, v);
    chk("t5b_r2", v, 0);

    // 6: reset during the MEM cycle of a store
    clear_prog();
    prog[0] = i_ins(OP_ADDI, 1, 0, 16'h0077);
    prog[1] = i_ins(OP_SW, 1, 0, 16'd8);
    do_reset();
    pulse_run();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #2;
      if (cyc == m_ret_cyc && m_ir[31:26] == 6'h2B) found = 1;
    end
    chk("t6_reach_mem", found, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_req", imem_req, 0);
    chk("t6_async_retire", retire, 0);
    chk("t6_async_pc", pc, 0);
    chk("t6_async_halted", halted, 0);
    chk("t6_async_trap", trap, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    clear_prog();
    prog[0] = i_ins(OP_LW, 5, 0, 16'd8);
    pulse_run();
    wait_halt("t6_halt", 100);
    read_reg(5, v);
    chk("t6_ram_kept", v, 32'h1234);

    // 7: randomized programs with random fetch stalls
    rand_stall = 1;
    for (int p = 0; p < 3; p++) begin
      clear_prog();
      k = 0;
      for (int r = 1; r < 8; r++) prog[k++] = i_ins(OP_ADDI, r, 0, 16'($urandom));
      for (int m = 0; m < 16; m++) prog[k++] = i_ins(OP_SW, m % 8, 0, 16'(m));
      for (int n = 0; n < 60; n++) begin
        a = int'($urandom_range(0, 7));
        b = int'($urandom_range(0, 7));
        d = int'($urandom_range(0, 7));
        case ($urandom_range(0, 10))
          0: prog[k] = r_ins(d, a, b, 0, FN_ADD);
          1: prog[k] = r_ins(d, a, b, 0, FN_SUB);
          2: prog[k] = r_ins(d, a, b, 0, FN_AND);
          3: prog[k] = r_ins(d, a, b, 0, FN_OR);
          4: prog[k] = r_ins(d, a, b, 0, FN_SLT);
          5: prog[k] = r_ins(d, 0, b, int'($urandom_range(0, 31)), FN_SLL);
          6: prog[k] = i_ins(OP_ADDI, d, a, 16'($urandom));
          7: prog[k] = i_ins(OP_LW, d, 0, 16'($urandom_range(0, 15)));
          8: prog[k] = i_ins(OP_SW, b, 0, 16'($urandom_range(0, 15)));
          9: prog[k] = i_ins(OP_BEQ, b, a, 16'($urandom_range(0, 3)));
          default: prog[k] = {OP_J, 26'(k + int'($urandom_range(1, 4)))};
        endcase
        k++;
      end
      do_reset();
      pulse_run();
      wait_halt("t7_halt", 3000);
      pulse_run();
      wait_halt("t7_rehalt", 100);
    end
    rand_stall = 0;

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
